pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the fetch stage. Holds the PC and advances it by a fixed instruction step. Resolves conditional branches from the Z/N/V flags and redirects to a PC-relative immediate target or an absolute register target. Adds three things to the single-cycle PC updater: a fetch stall, a flush pulse on taken branches, and a halt state machine that drains the pipeline before reporting halted.

## Interface
Parameters:
- ADDR_W, 16, width of PC, targets and immediates
- STEP, 2, byte increment per sequential instruction
- IMM_SHIFT, 1, left shift applied to the immediate offset
- RESET_PC, 0, PC value loaded on reset
- DRAIN_CYCLES, 3, cycles spent in DRAIN before HALTED (≥1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold the PC and the FSM this cycle
- branch  in  1  current instruction is a branch
- cond  in  3  condition code
- z, n, v  in  1 each  flags
- addr_src  in  1  1 = PC-relative immediate target, 0 = register target
- imm  in  ADDR_W  signed branch offset, in instructions
- reg_addr  in  ADDR_W  absolute register target
- hlt  in  1  halt instruction in fetch
- pc  out  ADDR_W  current PC (registered)
- pc_plus  out  ADDR_W  pc + STEP, combinational; used as the link value
- taken  out  1  branch taken this cycle, combinational
- flush  out  1  registered one-cycle pulse after a taken branch is committed
- halted  out  1  registered; high in HALTED
- br_count, br_taken  out  16 each  present only with PC_BRANCH_STATS_EN

## Operation
- Condition decode:
  - 000 NE: ~z
  - 001 EQ: z
  - 010 GT: ~z & ~n
  - 011 LT: n
  - 100 GE: z | ~n
  - 101 LE: n | z
  - 110 OV: v
  - 111 always
- taken = branch & cond_true & state==RUN.
- Targets, all arithmetic modulo 2^ADDR_W (wrap-around, no carry out):
  - Immediate target = pc_plus + (imm << IMM_SHIFT).
  - Register target = reg_addr, unshifted.
- FSM states: RUN, DRAIN, HALTED.
- RUN:
  - stall → PC, FSM and flush all hold; flush outputs 0.
  - else hlt → PC holds; load drain counter with DRAIN_CYCLES−1; go to DRAIN. Branch is ignored.
  - else taken → PC ← target; flush ← 1.
  - else PC ← pc_plus.
- DRAIN: PC holds. Counter decrements each cycle stall is low. At 0, go to HALTED.
- HALTED: PC frozen; halted = 1. Only rst exits.
- Priority: rst > stall > hlt > branch.
- taken is forced 0 outside RUN.

## Timing
- Reset values:
  - pc = RESET_PC
  - state = RUN
  - flush = 0
  - halted = 0
  - drain counter = 0
  - stats = 0
- Redirect latency is 1 cycle: taken sampled at edge k, and pc = target after edge k.
- flush is high for exactly the one cycle following the redirect edge.
- Halt:
  - With no stalls, halted rises DRAIN_CYCLES edges after the edge that samples hlt.
  - Stall cycles during DRAIN extend this one-for-one.
- Reset asserted mid-DRAIN or in HALTED returns immediately (asynchronously) to RUN with pc = RESET_PC.
- Branch target equal to the current pc (self-loop) is legal and is re-evaluated each cycle.

## Configuration
- PC_BRANCH_STATS_EN defined:
  - br_count increments on each non-stalled RUN cycle with branch=1 and hlt=0.
  - br_taken increments on each such cycle with taken=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: both counters and their ports are absent, and the behaviour of every other port is identical.

## Structure
- Shared package pc_pkg holds:
  - cond code localparams: COND_NE … COND_AL
  - FSM state typedef: ST_RUN, ST_DRAIN, ST_HALTED
- Sub-module pc_cond_eval: purely combinational (cond, z, n, v) → cond_true. It is reused by the execute-stage branch check.
- The top level holds the PC register, target adders, FSM, drain counter and optional stats.

## Test plan
- Reset with RESET_PC=16'h0100, no branches, 4 cycles → pc 0100, 0102, 0104, 0106, 0108; flush=0.
- pc=16'h0010, branch=1, cond=001, z=1, addr_src=1, imm=−3 → next pc = 0012 + (−6) = 000C; flush=1 for one cycle.
- pc=16'hFFFE, no branch → pc wraps to 0000. Imm target past FFFF wraps likewise.
- cond sweep 000–111 against all 8 z/n/v combinations → taken matches the decode list. Register target reg_addr=16'h1234 is loaded unshifted.
- hlt at pc=16'h0040, DRAIN_CYCLES=3, with one stall cycle during DRAIN:
  - halted rises after 4 edges.
  - pc stays 0040.
  - A branch issued during DRAIN is ignored.
  - rst then returns the sequencer to RUN with pc=RESET_PC.
- With PC_BRANCH_STATS_EN:
  - 3 branches (2 taken, 1 stalled extra cycle) → br_count=3, br_taken=2.
  - Preset near saturation → counters hold at FFFF.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage PC sequencer and the
// execute-stage branch check.
//   COND_*      3-bit branch condition codes
//   pc_state_t  sequencer FSM state (RUN / DRAIN / HALTED)
package pc_pkg;
   localparam logic [2:0] COND_NE = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_GT = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_GE = 3'b100;
   localparam logic [2:0] COND_LE = 3'b101;
   localparam logic [2:0] COND_OV = 3'b110;
   localparam logic [2:0] COND_AL = 3'b111;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } pc_state_t;
endpackage

// File: rtl/pc_cond_eval.sv
// pc_cond_eval: purely combinational branch-condition evaluator.
//   cond       in  3  condition code (COND_*)
//   z, n, v    in  1  zero / negative / overflow flags
//   cond_true  out 1  condition holds for the given flags
module pc_cond_eval
   import pc_pkg::*;
(
   input  logic [2:0] cond,
   input  logic       z,
   input  logic       n,
   input  logic       v,
   output logic       cond_true
);

   always_comb begin
      cond_true = 1'b0;
      case (cond)
         COND_NE: cond_true = ~z;
         COND_EQ: cond_true = z;
         COND_GT: cond_true = ~z & ~n;
         COND_LT: cond_true = n;
         COND_GE: cond_true = z | ~n;
         COND_LE: cond_true = n | z;
         COND_OV: cond_true = v;
         COND_AL: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with branch redirect, fetch
// stall, one-cycle flush pulse after taken branches, and a halt FSM that
// drains the pipeline for DRAIN_CYCLES un-stalled cycles before HALTED.
//   clk, rst            clock / async active-high reset
//   stall               hold PC and FSM this cycle
//   branch, cond, z/n/v branch request and flags
//   addr_src            1 = pc_plus + (imm << IMM_SHIFT), 0 = reg_addr
//   imm, reg_addr       target sources
//   hlt                 halt instruction in fetch
//   pc, pc_plus         registered PC and its sequential successor
//   taken               branch taken this cycle (combinational)
//   flush, halted       registered status
//   br_count, br_taken  branch statistics, only with PC_BRANCH_STATS_EN
// Optional feature macro: PC_BRANCH_STATS_EN
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                ADDR_W       = 16,
   parameter int                STEP         = 2,
   parameter int                IMM_SHIFT    = 1,
   parameter logic [ADDR_W-1:0] RESET_PC     = '0,
   parameter int                DRAIN_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch,
   input  logic [2:0]        cond,
   input  logic              z,
   input  logic              n,
   input  logic              v,
   input  logic              addr_src,
   input  logic [ADDR_W-1:0] imm,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic              hlt,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus,
   output logic              taken,
   output logic              flush,
`ifdef PC_BRANCH_STATS_EN
   output logic [15:0]       br_count,
   output logic [15:0]       br_taken,
`endif
   output logic              halted
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   pc_state_t         r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [CNT_W-1:0]  r_drain;
   logic              r_flush;
   logic              r_halted;

   logic              w_cond_true;
   logic [ADDR_W-1:0] w_imm_off;
   logic [ADDR_W-1:0] w_target;

   pc_cond_eval u_cond (
      .cond      (cond),
      .z         (z),
      .n         (n),
      .v         (v),
      .cond_true (w_cond_true)
   );

   // All target arithmetic is truncated to ADDR_W, giving natural wrap.
   assign pc_plus   = r_pc + ADDR_W'(STEP);
   assign w_imm_off = imm << IMM_SHIFT;
   assign w_target  = addr_src ? (pc_plus + w_imm_off) : reg_addr;
   assign taken     = branch & w_cond_true & (r_state == ST_RUN);

   assign pc     = r_pc;
   assign flush  = r_flush;
   assign halted = r_halted;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_RUN;
         r_pc     <= RESET_PC;
         r_drain  <= '0;
         r_flush  <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         // flush is a single-cycle pulse; only a committed redirect re-arms it
         r_flush <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (!stall) begin
                  if (hlt) begin
                     r_state <= ST_DRAIN;
                     r_drain <= CNT_W'(DRAIN_CYCLES - 1);
                  end else if (taken) begin
                     r_pc    <= w_target;
                     r_flush <= 1'b1;
                  end else begin
                     r_pc <= pc_plus;
                  end
               end
            end
            ST_DRAIN: begin
               if (!stall) begin
                  if (r_drain == '0) begin
                     r_state  <= ST_HALTED;
                     r_halted <= 1'b1;
                  end else begin
                     r_drain <= r_drain - 1'b1;
                  end
               end
            end
            ST_HALTED: ;
            default: r_state <= ST_RUN;
         endcase
      end
   end

`ifdef PC_BRANCH_STATS_EN
   logic        w_br_evt;
   logic [15:0] r_br_count;
   logic [15:0] r_br_taken;

   // A branch is counted only when it is actually considered for redirect.
   assign w_br_evt = (r_state == ST_RUN) & ~stall & branch & ~hlt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_br_count <= '0;
         r_br_taken <= '0;
      end else if (w_br_evt) begin
         if (r_br_count != 16'hFFFF)
            r_br_count <= r_br_count + 16'd1;
         if (taken && r_br_taken != 16'hFFFF)
            r_br_taken <= r_br_taken + 16'd1;
      end
   end

   assign br_count = r_br_count;
   assign br_taken = r_br_taken;
`endif

endmodule
